// File: rtl/e203_exu_wbck_arb.sv
// e203_exu_wbck_arb: ALU/long-pipe regfile write-back arbiter with OITF ordering, output slot and ALU starvation guard.
// Optional statistics counters are enabled by defining E203_WBCK_ARB_STAT_EN.
module e203_exu_wbck_arb #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int ITAG_W     = 2,
  parameter int STARVE_MAX = 3,
  parameter int STAT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  input  logic [ITAG_W-1:0]  longp_wbck_i_itag,
  input  logic               oitf_empty,
  input  logic [ITAG_W-1:0]  oitf_ret_ptr,
  output logic               oitf_ret_ena,
  output logic               rf_wbck_o_valid,
  input  logic               rf_wbck_o_ready,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic               rf_wbck_o_src
`ifdef E203_WBCK_ARB_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [STAT_W-1:0]  stat_alu_cnt,
  output logic [STAT_W-1:0]  stat_lp_cnt,
  output logic [STAT_W-1:0]  stat_stall_cnt
`endif
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  typedef enum logic {LP_PRI, ALU_PRI} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic slot_valid_q;
  logic load_en, lp_elig, contest, grant_alu, grant_lp, alu_hs, lp_hs;
  always_comb begin
    load_en   = ~slot_valid_q | rf_wbck_o_ready;
    lp_elig   = longp_wbck_i_valid & ~oitf_empty & (longp_wbck_i_itag == oitf_ret_ptr);
    contest   = alu_wbck_i_valid & lp_elig;
    grant_alu = alu_wbck_i_valid & (~lp_elig | (state_q == ALU_PRI));
    grant_lp  = lp_elig & (~alu_wbck_i_valid | (state_q == LP_PRI));
    alu_wbck_i_ready   = load_en & grant_alu;
    longp_wbck_i_ready = load_en & grant_lp;
    alu_hs = alu_wbck_i_valid & alu_wbck_i_ready;
    lp_hs  = longp_wbck_i_valid & longp_wbck_i_ready;
    oitf_ret_ena = lp_hs;
    cnt_d = ~load_en ? cnt_q : grant_alu ? '0 : ~contest ? cnt_q : (cnt_q == SMAX) ? cnt_q : cnt_q + 1'b1;
    state_d = (state_q == LP_PRI) ? ((cnt_d == SMAX) ? ALU_PRI : LP_PRI) : (alu_hs ? LP_PRI : ALU_PRI);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= LP_PRI;
      cnt_q           <= '0;
      slot_valid_q    <= 1'b0;
      rf_wbck_o_wdat  <= '0;
      rf_wbck_o_rdidx <= '0;
      rf_wbck_o_src   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_en) begin
        slot_valid_q <= alu_hs | lp_hs;
        if (alu_hs | lp_hs) begin
          rf_wbck_o_wdat  <= lp_hs ? longp_wbck_i_wdat : alu_wbck_i_wdat;
          rf_wbck_o_rdidx <= lp_hs ? longp_wbck_i_rdidx : alu_wbck_i_rdidx;
          rf_wbck_o_src   <= lp_hs;
        end
      end
    end
  end
  assign rf_wbck_o_valid = slot_valid_q;
`ifdef E203_WBCK_ARB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst | stat_clr) begin
      stat_alu_cnt   <= '0;
      stat_lp_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (alu_hs & ~&stat_alu_cnt) stat_alu_cnt <= stat_alu_cnt + 1'b1;
      if (lp_hs & ~&stat_lp_cnt) stat_lp_cnt <= stat_lp_cnt + 1'b1;
      if (slot_valid_q & ~rf_wbck_o_ready & ~&stat_stall_cnt) stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// tb_e203_exu_wbck_arb: table-driven directed bench for the write-back arbiter.
module tb_e203_exu_wbck_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic alu_v = 0, alu_r, lp_v = 0, lp_r, oitf_empty = 1, ret_ena, o_v, rf_r = 1, o_src;
  logic [31:0] alu_wd = 0, lp_wd = 0, o_wd;
  logic [4:0] alu_rd = 0, lp_rd = 0, o_rd;
  logic [1:0] lp_tag = 0, ret_ptr = 0;
  int n_run = 0, n_fail = 0;
`ifdef E203_WBCK_ARB_STAT_EN
  logic stat_clr = 0;
  logic [15:0] s_alu, s_lp, s_stall;
`endif
  always #5 clk = ~clk;
  e203_exu_wbck_arb dut (
    .clk(clk), .rst(rst),
    .alu_wbck_i_valid(alu_v), .alu_wbck_i_ready(alu_r), .alu_wbck_i_wdat(alu_wd), .alu_wbck_i_rdidx(alu_rd),
    .longp_wbck_i_valid(lp_v), .longp_wbck_i_ready(lp_r), .longp_wbck_i_wdat(lp_wd),
    .longp_wbck_i_rdidx(lp_rd), .longp_wbck_i_itag(lp_tag),
    .oitf_empty(oitf_empty), .oitf_ret_ptr(ret_ptr), .oitf_ret_ena(ret_ena),
    .rf_wbck_o_valid(o_v), .rf_wbck_o_ready(rf_r), .rf_wbck_o_wdat(o_wd),
    .rf_wbck_o_rdidx(o_rd), .rf_wbck_o_src(o_src)
`ifdef E203_WBCK_ARB_STAT_EN
    , .stat_clr(stat_clr), .stat_alu_cnt(s_alu), .stat_lp_cnt(s_lp), .stat_stall_cnt(s_stall)
`endif
  );
  typedef struct {
    logic a; logic [4:0] ar; logic l; logic [4:0] lr; logic [1:0] t; logic e; logic [1:0] p; logic r;
    logic xa; logic xl; logic xv; logic [4:0] xrd; logic xs;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(int a, int ar, int l, int lr, int t, int e, int p, int r,
                              int xa, int xl, int xv, int xrd, int xs);
    vec_t v;
    v.a = 1'(a); v.ar = 5'(ar); v.l = 1'(l); v.lr = 5'(lr); v.t = 2'(t); v.e = 1'(e); v.p = 2'(p); v.r = 1'(r);
    v.xa = 1'(xa); v.xl = 1'(xl); v.xv = 1'(xv); v.xrd = 5'(xrd); v.xs = 1'(xs);
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic apply(vec_t v, string tag);
    alu_v = v.a; alu_rd = v.ar; alu_wd = 32'hA000_0000 | 32'(v.ar);
    lp_v = v.l; lp_rd = v.lr; lp_wd = 32'hB000_0000 | 32'(v.lr); lp_tag = v.t;
    oitf_empty = v.e; ret_ptr = v.p; rf_r = v.r;
    #2;
    chk({tag, " alu_ready"}, 32'(alu_r), 32'(v.xa));
    chk({tag, " lp_ready"}, 32'(lp_r), 32'(v.xl));
    chk({tag, " ret_ena"}, 32'(ret_ena), 32'(v.xl));
    @(posedge clk); #1;
    chk({tag, " o_valid"}, 32'(o_v), 32'(v.xv));
    if (v.xv) begin
      chk({tag, " o_rdidx"}, 32'(o_rd), 32'(v.xrd));
      chk({tag, " o_src"}, 32'(o_src), 32'(v.xs));
      chk({tag, " o_wdat"}, o_wd, (v.xs ? 32'hB000_0000 : 32'hA000_0000) | 32'(v.xrd));
    end
  endtask
  vec_t lpw, alw, idle;
  initial begin
    lpw  = mk(1, 10, 1, 20, 0, 0, 0, 1, 0, 1, 1, 20, 1);
    alw  = mk(1, 10, 1, 20, 0, 0, 0, 1, 1, 0, 1, 10, 0);
    idle = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, i, 0, 0, 0, 1, 0, 1, 1, 0, 1, i, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 0, 1, 7, 1, 0, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 2, 0, 2, 1, 0, 1, 1, 7, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 2, 1, 2, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) tbl.push_back(lpw);
      tbl.push_back(alw);
    end
    tbl.push_back(lpw);
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 10, 1, 21, 0, 0, 0, 0, 0, 0, 1, 20, 1));
    tbl.push_back(mk(1, 10, 1, 21, 0, 0, 0, 1, 0, 1, 1, 21, 1));
    tbl.push_back(mk(1, 10, 1, 22, 0, 0, 0, 1, 0, 1, 1, 22, 1));
    tbl.push_back(mk(0, 10, 1, 23, 0, 0, 0, 1, 0, 1, 1, 23, 1));
    tbl.push_back(mk(1, 10, 1, 24, 0, 0, 0, 1, 1, 0, 1, 10, 0));
    tbl.push_back(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("reset o_valid", 32'(o_v), 0);
    chk("reset o_rdidx", 32'(o_rd), 0);
    chk("reset o_src", 32'(o_src), 0);
    chk("reset o_wdat", o_wd, 0);
    chk("reset ret_ena", 32'(ret_ena), 0);
    rst = 0;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    apply(lpw, "rst_pre0");
    apply(lpw, "rst_pre1");
    apply(mk(1, 10, 1, 25, 0, 0, 0, 0, 0, 0, 1, 20, 1), "rst_hold");
    rst = 1;
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "rst_mid");
    rst = 0;
    for (int i = 0; i < 3; i++) apply(lpw, $sformatf("post_rst_lp%0d", i));
    apply(alw, "post_rst_alu");
    apply(idle, "post_rst_idle");
`ifdef E203_WBCK_ARB_STAT_EN
    stat_clr = 1;
    apply(idle, "stat_clr0");
    stat_clr = 0;
    for (int i = 1; i <= 3; i++) apply(mk(1, i, 0, 0, 0, 1, 0, 1, 1, 0, 1, i, 0), "stat_alu");
    for (int i = 0; i < 2; i++) apply(mk(0, 0, 1, 9, 0, 0, 0, 1, 0, 1, 1, 9, 1), "stat_lp");
    for (int i = 0; i < 4; i++) apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 9, 1), "stat_stall");
    chk("stat_alu_cnt", 32'(s_alu), 3);
    chk("stat_lp_cnt", 32'(s_lp), 2);
    chk("stat_stall_cnt", 32'(s_stall), 4);
    stat_clr = 1;
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 9, 1), "stat_clr1");
    stat_clr = 0;
    chk("stat_alu_clr", 32'(s_alu), 0);
    chk("stat_lp_clr", 32'(s_lp), 0);
    chk("stat_stall_clr", 32'(s_stall), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/e203_exu_wbck_arb.md
Name: e203_exu_wbck_arb

Overview:
- Arbitrates the single integer regfile write port between the ALU short-pipe write-back and the long-pipe write-back.
- Long-pipe results are accepted only in OITF order, and each accepted long-pipe result retires its OITF entry.
- The grant goes through a one-entry registered output slot, with starvation protection for the ALU.
- Sits between the ALU/long-pipe write-back logic and the regfile write port in the EXU.

Parameters:
- XLEN, 32, write-back data width
- RFIDX_W, 5, register index width
- ITAG_W, 2, instruction tag width (OITF depth 4)
- STARVE_MAX, 3, consecutive lost contested cycles before the ALU is forced to win; must be >= 1
- STAT_W, 16, statistics counter width (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- alu_wbck_i_valid  in  1  ALU result valid
- alu_wbck_i_ready  out  1  ALU result accepted
- alu_wbck_i_wdat  in  XLEN  ALU result data
- alu_wbck_i_rdidx  in  RFIDX_W  ALU destination register
- longp_wbck_i_valid  in  1  long-pipe result valid
- longp_wbck_i_ready  out  1  long-pipe result accepted
- longp_wbck_i_wdat  in  XLEN  long-pipe result data
- longp_wbck_i_rdidx  in  RFIDX_W  long-pipe destination register
- longp_wbck_i_itag  in  ITAG_W  long-pipe instruction tag
- oitf_empty  in  1  OITF has no entries
- oitf_ret_ptr  in  ITAG_W  tag of the oldest OITF entry
- oitf_ret_ena  out  1  retire the oldest OITF entry
- rf_wbck_o_valid  out  1  regfile write request
- rf_wbck_o_ready  in  1  regfile accepted the write
- rf_wbck_o_wdat  out  XLEN  write data
- rf_wbck_o_rdidx  out  RFIDX_W  write index
- rf_wbck_o_src  out  1  source of the write: 0 = ALU, 1 = long-pipe

Behaviour:
- Output slot: one register entry holding valid, wdat, rdidx and src.
  - load_en = ~slot_valid | rf_wbck_o_ready.
  - Latency is 1 cycle from input handshake to rf_wbck_o_valid.
  - If the slot drains and reloads in the same cycle, throughput is 1 write/cycle.
- If the slot holds an entry and rf_wbck_o_ready=0, the slot holds and both input readys are 0.
- Long-pipe eligibility: lp_elig = longp_wbck_i_valid & ~oitf_empty & (longp_wbck_i_itag == oitf_ret_ptr).
  - If oitf_empty=1, the long-pipe is never eligible.
  - A tag mismatch leaves longp_wbck_i_ready=0.
- Arbiter FSM, two states:
  - LP_PRI (reset state): if alu valid and lp_elig are both set, long-pipe wins.
  - ALU_PRI: ALU wins a contested cycle.
  - An uncontested requester always wins when load_en=1.
- Starvation counter, ceil(log2(STARVE_MAX+1)) bits:
  - Increments on each cycle where load_en=1 and the ALU loses a contest.
  - Saturates at STARVE_MAX.
  - Clears whenever the ALU is granted.
  - Cycles with load_en=0 do not count.
- FSM transitions:
  - LP_PRI -> ALU_PRI when the counter reaches STARVE_MAX.
  - ALU_PRI -> LP_PRI on the ALU grant; the counter clears in the same cycle.
  - ALU_PRI with the ALU not valid: stays in ALU_PRI and the long-pipe may be granted.
- alu_wbck_i_ready = load_en & grant_alu; longp_wbck_i_ready = load_en & grant_lp. At most one is 1.
- oitf_ret_ena = longp_wbck_i_valid & longp_wbck_i_ready. This is combinational, one pulse per accepted long-pipe result, asserted at slot load, not at regfile accept.
- rdidx 0 is passed through unchanged; the regfile ignores x0.
- Reset values: slot_valid=0, rf_wbck_o_valid=0, wdat=0, rdidx=0, src=0, state=LP_PRI, counter=0, oitf_ret_ena=0.
- Reset mid-operation drops any held slot entry with no write. The OITF entry was already retired at load.
- Inputs are sampled only on handshake; no input is registered.

Optional Feature:
- Macro: E203_WBCK_ARB_STAT_EN.
- When defined, add the following ports:
  - stat_clr  in  1  clear all statistics counters
  - stat_alu_cnt  out  STAT_W  ALU grants
  - stat_lp_cnt  out  STAT_W  long-pipe grants
  - stat_stall_cnt  out  STAT_W  cycles with slot_valid & ~rf_wbck_o_ready
- Counter rules: all counters saturate, reset to 0, and clear on stat_clr; stat_clr has priority over increment.
- When undefined: no ports, no counters, identical arbitration behaviour.

Test Plan:
- ALU-only stream: alu valid 4 cycles, rdidx 1..4, rf_ready=1 -> writes appear 1 cycle later, src=0, oitf_ret_ena never 1.
- Long-pipe order: oitf_ret_ptr=2, longp itag=1 -> longp_ready=0. Then change itag to 2 -> ready=1, oitf_ret_ena=1 for 1 cycle, the write appears next cycle with src=1.
- Contest and starvation: both valid every cycle, lp_elig held, STARVE_MAX=3 -> grant order LP, LP, LP, ALU, LP, LP, LP, ALU.
- Backpressure: slot full, rf_ready=0 for 5 cycles -> both readys 0, counter unchanged, output stable. rf_ready=1 -> drain and reload in the same cycle.
- Reset mid-hold: slot valid, rf_ready=0, rst=1 for 1 cycle -> rf_wbck_o_valid=0 next cycle, state LP_PRI, counter 0.
- STAT_EN: 3 ALU grants, 2 long-pipe grants, 4 stall cycles -> counters 3/2/4. stat_clr -> all 0 next cycle.
